des_key_schedule: RTL and testbench

Iterative DES key scheduler that produces the 48-bit round subkey XORed with the expanded right half ahead of the S-box stage (`sbox1`…`sbox8`) in the Feistel round datapath. It loads a 64-bit key, applies PC-1, and steps through rounds 1–16 on request. Each step applies the per-round rotation and presents PC-2 of the current C/D halves. It supports encrypt order (K1→K16) and decrypt order (K16→K1) without precomputing or storing all subkeys.

---
 rtl/des_pkg.sv | 46 ++++
 rtl/des_pc2.sv | 16 +
 rtl/des_key_schedule.sv | 94 +++++++++
 tb/tb_des_key_schedule.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: key-schedule state encoding, shift schedule and PC-1/PC-2 tables.
// Table entries are DES bit numbers (1 = MSB of the source vector).
package des_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } ks_state_e;

  localparam int unsigned Pc1Table [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Table [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Index r-1 holds the left-rotation amount for round r.
  localparam logic [1:0] ShiftSched [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
    unique case (s)
      2'd1:    rotl28 = {x[26:0], x[27]};
      2'd2:    rotl28 = {x[25:0], x[27:26]};
      default: rotl28 = x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
    unique case (s)
      2'd1:    rotr28 = {x[0], x[27:1]};
      2'd2:    rotr28 = {x[1:0], x[27:2]};
      default: rotr28 = x;
    endcase
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: combinational 56-bit C||D to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] i_cd,
  output logic [47:0] o_subkey
);

  always_comb begin
    o_subkey = '0;
    for (int i = 0; i < 48; i++) begin
      o_subkey[6'(47 - i)] = i_cd[6'(56 - Pc2Table[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key scheduler: one subkey per step, encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_key,
  input  logic        i_load,
  input  logic        i_decrypt,
  input  logic        i_next,
  output logic [47:0] o_subkey,
  output logic [3:0]  o_round,
  output logic        o_valid,
  output logic        o_done
);

  ks_state_e   state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;

  logic [55:0] pc1_cd;
  logic [47:0] pc2_out;
  logic [1:0]  enc_shift, dec_shift;

  // Parity bits are never selected by PC-1, so they drop out here.
  always_comb begin
    pc1_cd = '0;
    for (int i = 0; i < 56; i++) begin
      pc1_cd[6'(55 - i)] = i_key[6'(64 - Pc1Table[i])];
    end
  end

  // Encrypt moves from round n+1 to n+2; decrypt undoes the shift of round 16-n.
  assign enc_shift = ShiftSched[cnt_q + 4'd1];
  assign dec_shift = ShiftSched[4'd15 - cnt_q];

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (i_load) begin
      state_d = StActive;
      dir_d   = i_decrypt;
      cnt_d   = 4'd0;
      // C16/D16 equal C0/D0, so decrypt starts from the unrotated halves.
      c_d     = i_decrypt ? pc1_cd[55:28] : rotl28(pc1_cd[55:28], 2'd1);
      d_d     = i_decrypt ? pc1_cd[27:0]  : rotl28(pc1_cd[27:0], 2'd1);
    end else if (i_next && (state_q == StActive)) begin
      if (cnt_q == 4'd15) begin
        state_d = StIdle;
        cnt_d   = 4'd0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
        c_d   = dir_q ? rotr28(c_q, dec_shift) : rotl28(c_q, enc_shift);
        d_d   = dir_q ? rotr28(d_q, dec_shift) : rotl28(d_q, enc_shift);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .i_cd     ({c_q, d_q}),
    .o_subkey (pc2_out)
  );

  assign o_valid  = (state_q == StActive);
  assign o_subkey = o_valid ? pc2_out : '0;
  assign o_round  = o_valid ? cnt_q : 4'd0;
  assign o_done   = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: cycle model feeds an expected-output queue.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key;
  logic        load, decrypt, nxt;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        valid, done;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] TestKey = 64'h133457799BBCDFF1;
  localparam logic [63:0] ParityMask = 64'h0101010101010101;

  typedef struct packed {
    logic        done;
    logic        valid;
    logic [3:0]  round;
    logic [47:0] subkey;
  } obs_t;

  obs_t exp_q[$];

  int tb_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int tb_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int tb_shift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Model state
  logic        m_active;
  logic        m_dec;
  int          m_n;
  logic [55:0] m_cd0;

  des_key_schedule dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_key     (key),
    .i_load    (load),
    .i_decrypt (decrypt),
    .i_next    (nxt),
    .o_subkey  (subkey),
    .o_round   (round),
    .o_valid   (valid),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout need finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - tb_pc1[i])];
    return r;
  endfunction

  // Round r (1..16) key from C0/D0 via cumulative single-bit rotations.
  function automatic logic [47:0] f_key(input logic [55:0] cd0, input int r);
    logic [27:0] c = cd0[55:28];
    logic [27:0] d = cd0[27:0];
    logic [55:0] cd;
    logic [47:0] k = '0;
    int tot = 0;
    for (int j = 0; j < r; j++) tot += tb_shift[j];
    for (int j = 0; j < tot; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - tb_pc2[i])];
    return k;
  endfunction

  task automatic cycle(input logic ld, input logic dec, input logic [63:0] k, input logic nx);
    obs_t e;
    obs_t got;
    logic m_done = 1'b0;
    @(negedge clk);
    load = ld; decrypt = dec; key = k; nxt = nx;
    if (ld) begin
      m_active = 1'b1; m_n = 0; m_dec = dec; m_cd0 = f_pc1(k);
    end else if (nx && m_active) begin
      if (m_n == 15) begin
        m_active = 1'b0; m_n = 0; m_done = 1'b1;
      end else begin
        m_n++;
      end
    end
    e.done   = m_done;
    e.valid  = m_active;
    e.round  = m_active ? 4'(m_n) : 4'd0;
    e.subkey = m_active ? f_key(m_cd0, m_dec ? 16 - m_n : m_n + 1) : 48'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0; nxt = 1'b0;
    got = {done, valid, round, subkey};
    if (exp_q.size() == 0) check_eq("queue_empty", 64'd1, 64'd0);
    else check_eq($sformatf("cyc r%0d", m_n), 64'(got), 64'(exp_q.pop_front()));
  endtask

  task automatic run_steps(input int n, input logic [63:0] k);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, k, 1'b1);
  endtask

  initial begin
    logic [63:0] rk;
    rst = 1'b1; key = '0; load = 1'b0; decrypt = 1'b0; nxt = 1'b0;
    m_active = 1'b0; m_dec = 1'b0; m_n = 0; m_cd0 = '0;
    #12;
    check_eq("reset_outs", 64'({done, valid, round, subkey}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle next is ignored
    cycle(1'b0, 1'b0, TestKey, 1'b1);

    // Encrypt order
    cycle(1'b1, 1'b0, TestKey, 1'b0);
    check_eq("enc_k1", 64'(subkey), 64'h1B02EFFC7072);
    cycle(1'b0, 1'b0, TestKey, 1'b1);
    check_eq("enc_k2", 64'(subkey), 64'h79AED9DBC9E5);
    check_eq("enc_r1", 64'(round), 64'd1);
    run_steps(14, TestKey);
    check_eq("enc_k16", 64'(subkey), 64'hCB3D8B0E17F5);
    cycle(1'b0, 1'b0, TestKey, 1'b1);
    check_eq("enc_done", 64'({done, valid, subkey}), {14'd0, 2'b10, 48'd0});
    cycle(1'b0, 1'b0, TestKey, 1'b0);

    // Decrypt order
    cycle(1'b1, 1'b1, TestKey, 1'b0);
    check_eq("dec_k16", 64'(subkey), 64'hCB3D8B0E17F5);
    run_steps(15, TestKey);
    check_eq("dec_k1", 64'(subkey), 64'h1B02EFFC7072);
    cycle(1'b0, 1'b0, TestKey, 1'b1);
    cycle(1'b0, 1'b0, TestKey, 1'b0);

    // Parity bits flipped
    cycle(1'b1, 1'b0, TestKey ^ ParityMask, 1'b0);
    check_eq("par_k1", 64'(subkey), 64'h1B02EFFC7072);
    run_steps(15, TestKey);
    check_eq("par_k16", 64'(subkey), 64'hCB3D8B0E17F5);
    cycle(1'b0, 1'b0, TestKey, 1'b1);

    // Load beats next mid-run and at the final round
    cycle(1'b1, 1'b0, TestKey, 1'b0);
    run_steps(7, TestKey);
    cycle(1'b1, 1'b0, TestKey, 1'b1);
    check_eq("reload_k1", 64'(subkey), 64'h1B02EFFC7072);
    run_steps(15, TestKey);
    cycle(1'b1, 1'b1, TestKey, 1'b1);
    check_eq("reload_nodone", 64'(done), 64'd0);
    cycle(1'b0, 1'b0, TestKey, 1'b0);

    // Random keys, directions and step patterns
    for (int t = 0; t < 4; t++) begin
      rk = {$urandom, $urandom};
      cycle(1'b1, 1'($urandom_range(0, 1)), rk, 1'b0);
      for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, rk, 1'($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-run
    cycle(1'b1, 1'b0, TestKey, 1'b0);
    run_steps(9, TestKey);
    check_eq("pre_rst_round", 64'(round), 64'd9);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst", 64'({done, valid, round, subkey}), 64'd0);
    m_active = 1'b0; m_n = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b0, TestKey, 1'b1);
    cycle(1'b0, 1'b0, TestKey, 1'b1);
    cycle(1'b1, 1'b1, TestKey, 1'b0);
    check_eq("post_rst_k16", 64'(subkey), 64'hCB3D8B0E17F5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
